bunch_strobe_gen: RTL

- Next-generation bunch strobe generator for the sample-store timing path. Raises `bunch_strb` over a train of equally spaced sampling windows while `store_strb` is high.
- Bunch count, samples per bunch, spacing and first-bunch offset are runtime inputs. They are latched while idle, not fixed parameters.
- Adds a bunch index output, a train-done pulse and a configuration-error flag.
- Sits between the trigger/store logic and the ADC sample-capture blocks.

---
 rtl/timing_pkg.sv | 21 ++
 rtl/bunch_strobe_gen_window_cmp.sv | 57 +++++
 rtl/bunch_strobe_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/timing_pkg.sv
// Shared timing types and constants for the bunch strobe generator.
// Holds the FSM state encoding and the default counter/index widths.
package timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVE,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int CNT_W_DEF   = 11;
    localparam int BUNCH_W_DEF = 5;

    // Depth from the raw timing inputs to the strobe output: config latch
    // plus output register. The comparator works on the latched config and
    // the live cycle count, so the window lands with zero net offset.
    localparam int PIPE_COMP = 2;

endpackage

// File: rtl/bunch_strobe_gen_window_cmp.sv
// Window comparator: start/end accumulators for the current bunch and the
// equality compares against the live cycle count.
module window_cmp #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [CNT_W-1:0] s0_i,
    input  logic [CNT_W-1:0] ns_i,
    input  logic [CNT_W-1:0] sp_i,
    input  logic [CNT_W-1:0] t_i,
    output logic             start_hit_o,
    output logic             end_hit_o,
    output logic             next_hit_o
);

    // Latest start that can still open: 2^CNT_W-2.
    localparam logic [CNT_W:0] LIM = {1'b0, {(CNT_W-1){1'b1}}, 1'b0};

    logic [CNT_W:0] start_q, start_d;
    logic [CNT_W:0] end_q, end_d;
    logic [CNT_W:0] cur_start, cur_end, nxt_start, t_ext;

    // Current window bounds and the compares against the cycle count.
    always_comb begin
        t_ext     = {1'b0, t_i};
        cur_start = load_i ? {1'b0, s0_i} : start_q;
        cur_end   = load_i ? ({1'b0, s0_i} + {1'b0, ns_i}) : end_q;
        nxt_start = start_q + {1'b0, sp_i};
        start_hit_o = (cur_start <= LIM) && (cur_start == t_ext);
        end_hit_o   = (cur_end == t_ext);
        next_hit_o  = (nxt_start <= LIM) && (nxt_start == t_ext);
        start_d = start_q;
        end_d   = end_q;
        if (load_i) begin
            start_d = cur_start;
            end_d   = cur_end;
        end else if (adv_i) begin
            start_d = nxt_start;
            end_d   = end_q + {1'b0, sp_i};
        end
    end

    // Accumulator registers: load while idle, step by SP per bunch.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            end_q   <= '0;
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

endmodule

// File: rtl/bunch_strobe_gen.sv
// Bunch strobe generator: strobe train over equally spaced windows.
// Optional strb_count output enabled by macro BUNCH_STROBE_CNT_EN.
module bunch_strobe_gen
    import timing_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BUNCH_W = BUNCH_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               store_strb,
    input  logic [CNT_W-1:0]   b1_strobe,
    input  logic [BUNCH_W-1:0] no_bunches,
    input  logic [CNT_W-1:0]   no_samples,
    input  logic [CNT_W-1:0]   sample_spacing,
`ifdef BUNCH_STROBE_CNT_EN
    output logic [CNT_W+BUNCH_W-1:0] strb_count,
`endif
    output logic               bunch_strb,
    output logic [BUNCH_W-1:0] bunch_idx,
    output logic               train_done,
    output logic               cfg_err
);

    state_e state_q, state_d;

    logic [CNT_W-1:0]   t_q;
    logic [CNT_W-1:0]   s0_q, ns_q, sp_q;
    logic [BUNCH_W-1:0] nb_q;
    logic               armed_q;
    logic [BUNCH_W-1:0] k_q, k_d;
    logic               strb_q, strb_d;
    logic [BUNCH_W-1:0] idx_q, idx_d;
    logic               done_q, done_d;
    logic               err_q;

    logic cfg_bad, last, load, adv;
    logic start_hit, end_hit, next_hit;

    assign cfg_bad = (nb_q == '0) || (ns_q == '0) ||
                     ((nb_q > BUNCH_W'(1)) && (sp_q < ns_q));
    assign last = (k_q == (nb_q - BUNCH_W'(1)));
    assign load = (state_q == ST_IDLE);
    assign adv  = store_strb && (state_q == ST_ACTIVE) && end_hit && !last;

    window_cmp #(
        .CNT_W(CNT_W)
    ) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .adv_i       (adv),
        .s0_i        (s0_q),
        .ns_i        (ns_q),
        .sp_i        (sp_q),
        .t_i         (t_q),
        .start_hit_o (start_hit),
        .end_hit_o   (end_hit),
        .next_hit_o  (next_hit)
    );

    // Config latch: track the timing inputs while the store window is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= '0;
            ns_q <= '0;
            sp_q <= '0;
            nb_q <= '0;
        end else if (!store_strb) begin
            s0_q <= b1_strobe;
            ns_q <= no_samples;
            sp_q <= sample_spacing;
            nb_q <= no_bunches;
        end
    end

    // Arming: a train may only start on a store rise seen after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else if (!store_strb) begin
            armed_q <= 1'b1;
        end
    end

    // Cycle counter: value of t at the next edge, saturating.
    always_ff @(posedge clk) begin
        if (rst || !store_strb) begin
            t_q <= '0;
        end else if (t_q != '1) begin
            t_q <= t_q + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (!store_strb) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (armed_q && !cfg_bad) begin
                        state_d = start_hit ? ST_ACTIVE : ST_WAIT;
                    end
                end
                ST_WAIT, ST_GAP: begin
                    if (start_hit) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (end_hit) begin
                        if (last) begin
                            state_d = ST_DONE;
                        end else if (next_hit) begin
                            state_d = ST_ACTIVE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: next strobe, index and done pulse.
    always_comb begin
        k_d = k_q;
        if (state_d == ST_IDLE) begin
            k_d = '0;
        end else if (adv) begin
            k_d = k_q + BUNCH_W'(1);
        end
        strb_d = (state_d == ST_ACTIVE);
        idx_d  = idx_q;
        if (state_d == ST_IDLE) begin
            idx_d = '0;
        end else if (state_d == ST_ACTIVE) begin
            idx_d = k_d;
        end
        done_d = store_strb && (state_q == ST_ACTIVE) && end_hit && last;
    end

    // Registered outputs and bunch index.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            strb_q <= 1'b0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            strb_q <= strb_d;
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    // Config error: decided at train start, held until store drops.
    always_ff @(posedge clk) begin
        if (rst || !store_strb) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && armed_q) begin
            err_q <= cfg_bad;
        end
    end

`ifdef BUNCH_STROBE_CNT_EN
    logic [CNT_W+BUNCH_W-1:0] cnt_q;

    // Strobe-cycle counter: restarts at t = 0, holds once the train stops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (store_strb && state_q == ST_IDLE && armed_q) begin
            cnt_q <= {{(CNT_W+BUNCH_W-1){1'b0}}, strb_d};
        end else if (strb_d) begin
            cnt_q <= cnt_q + {{(CNT_W+BUNCH_W-1){1'b0}}, 1'b1};
        end
    end

    assign strb_count = cnt_q;
`endif

    assign bunch_strb = strb_q;
    assign bunch_idx  = idx_q;
    assign train_done = done_q;
    assign cfg_err    = err_q;

endmodule
